tx_arbiter: RTL

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/hangman_pkg.sv | 26 ++
 rtl/tx_slot.sv | 66 ++++++
 rtl/tx_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Purpose : shared types for the TX arbiter (FSM states, byte type, tie-break helper).
// Latency : n/a (types and a pure function only).
// Backpres: n/a.
package hangman_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GUARD
  } tx_state_e;

  // Shared down-counter width for the busy timeout and the guard gap.
  localparam int CNT_W = 16;

  // Round-robin pick: a lone pending slot wins, a tie goes to the side
  // that did not win last time.
  function automatic logic pick_b(input logic pend_a, input logic pend_b,
                                  input logic last_b);
    return pend_b && (!pend_a || !last_b);
  endfunction

endpackage

// File: rtl/tx_slot.sv
// Purpose : one-entry holding register for a single requester (capture, clear, drop).
// Latency : req -> pend/dat on the next edge; drop pulses one cycle after a lost request.
// Backpres: none upstream; a request hitting a full, ungranted slot is dropped.
//
// Ports:
//   clk, nRst      clock, synchronous active-low reset
//   req, data      one-cycle strobe and byte from the requester
//   clr            arbiter takes the byte this cycle
//   pend, dat      slot occupied / held byte
//   drop           one-cycle pulse: request lost because the slot was full
module tx_slot
  import hangman_pkg::*;
(
  input  logic       clk,
  input  logic       nRst,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       clr,
  output logic       pend,
  output logic [7:0] dat,
  output logic       drop
);

  logic  pend_q, pend_d;
  byte_t dat_q,  dat_d;
  logic  drop_q, drop_d;

  always_comb begin
    pend_d = pend_q;
    dat_d  = dat_q;
    drop_d = 1'b0;
    if (clr) begin
      pend_d = 1'b0;
    end
    // A request landing on the grant cycle reloads the slot in the same edge.
    if (req) begin
      if (!pend_q || clr) begin
        pend_d = 1'b1;
        dat_d  = data;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      pend_q <= 1'b0;
      dat_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      dat_q  <= dat_d;
      drop_q <= drop_d;
    end
  end

  assign pend = pend_q;
  assign dat  = dat_q;
  assign drop = drop_drop_alias();

  function automatic logic drop_drop_alias();
    return drop_q;
  endfunction

endmodule

// File: rtl/tx_arbiter.sv
// Purpose : round-robin arbiter feeding two byte requesters into one UART transmitter.
// Latency : request -> tx_ctrl two cycles later when idle; grant-to-grant >= 4 + GUARD_CYCLES.
// Backpres: launches only while transmit_ready is high; full slots drop new requests.
//
// Ports:
//   clk, nRst                 clock, synchronous active-low reset
//   req_a/data_a, req_b/data_b one-cycle request strobes with their bytes
//   transmit_ready            UART transmitter idle
//   tx_ctrl, tx_byte          one-cycle launch strobe and the byte it launches
//   pend_a, pend_b            slot holds an unsent byte
//   drop_a, drop_b            one-cycle pulse: request lost to a full slot
//   grant_b                   source of the current/most recent launch (1 = B)
//   tx_fault                  one-cycle pulse: UART never went busy after a launch
module tx_arbiter #(
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned BUSY_TIMEOUT = 8,
  parameter int unsigned START_PRIO   = 0
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  input  logic       transmit_ready,
  output logic       tx_ctrl,
  output logic [7:0] tx_byte,
  output logic       pend_a,
  output logic       pend_b,
  output logic       drop_a,
  output logic       drop_b,
  output logic       grant_b,
  output logic       tx_fault
);

  import hangman_pkg::*;

  localparam logic [31:0]      START_PRIO_V = 32'(START_PRIO);
  localparam logic             START_B      = START_PRIO_V[0];
  localparam logic [CNT_W-1:0] BUSY_LAST    = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);

  tx_state_e        state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             tx_ctrl_q,  tx_ctrl_d;
  byte_t            tx_byte_q,  tx_byte_d;
  logic             grant_b_q,  grant_b_d;
  logic             tx_fault_q, tx_fault_d;

  byte_t slot_dat_a, slot_dat_b;
  logic  grant, win_b, clr_a, clr_b;

  // Grant decision is combinational so the winning slot clears on the same
  // edge that loads tx_byte.
  always_comb begin
    grant = (state_q == ST_IDLE) && (pend_a || pend_b) && transmit_ready;
    win_b = pick_b(pend_a, pend_b, grant_b_q);
    clr_a = grant && !win_b;
    clr_b = grant && win_b;
  end

  tx_slot u_slot_a (
    .clk  (clk),
    .nRst (nRst),
    .req  (req_a),
    .data (data_a),
    .clr  (clr_a),
    .pend (pend_a),
    .dat  (slot_dat_a),
    .drop (drop_a)
  );

  tx_slot u_slot_b (
    .clk  (clk),
    .nRst (nRst),
    .req  (req_b),
    .data (data_b),
    .clr  (clr_b),
    .pend (pend_b),
    .dat  (slot_dat_b),
    .drop (drop_b)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_ctrl_d  = 1'b0;
    tx_byte_d  = tx_byte_q;
    grant_b_d  = grant_b_q;
    tx_fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          tx_byte_d = win_b ? slot_dat_b : slot_dat_a;
          grant_b_d = win_b;
          tx_ctrl_d = 1'b1;       // registered strobe is high for the LAUNCH cycle
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!transmit_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == BUSY_LAST) begin
          // UART never took the byte: report and move on, no retry.
          tx_fault_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (transmit_ready) begin
          cnt_d   = '0;
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        // A zero-length guard still spends the single GUARD cycle.
        if (GUARD_CYCLES == 0 || cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_ctrl_q  <= 1'b0;
      tx_byte_q  <= '0;
      grant_b_q  <= ~START_B;   // makes START_PRIO win the first tie
      tx_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_ctrl_q  <= tx_ctrl_d;
      tx_byte_q  <= tx_byte_d;
      grant_b_q  <= grant_b_d;
      tx_fault_q <= tx_fault_d;
    end
  end

  assign tx_ctrl  = tx_ctrl_q;
  assign tx_byte  = tx_byte_q;
  assign grant_b  = grant_b_q;
  assign tx_fault = tx_fault_q;

endmodule
